// File: rtl/light_cycles_pkg.sv
// Types and display codes shared by the Light Cycles start sequencer and the
// seven-segment display stage.
package light_cycles_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_GO,
    ST_RUN,
    ST_OVER
  } state_t;

  localparam logic [2:0] SC_THREE = 3'd0;
  localparam logic [2:0] SC_TWO   = 3'd1;
  localparam logic [2:0] SC_ONE   = 3'd2;
  localparam logic [2:0] SC_GO    = 3'd3;
  localparam logic [2:0] SC_BLANK = 3'd7;

endpackage

// File: rtl/tick_divider.sv
// Modulus counter: counts 0..MODULUS-1 while enabled and strobes tc on the
// last count, wrapping to zero on the following edge.
module tick_divider #(
  parameter int MODULUS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int W = (MODULUS > 1) ? $clog2(MODULUS) : 1;
  localparam logic [W-1:0] LAST = W'(MODULUS - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] count;
  logic         at_last;

  assign at_last = (count == LAST);

  // NOTE: sequential state is always updated with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= at_last ? '0 : count + ONE;
    end
  end

  assign tc = en & ~clr & at_last;

endmodule

// File: rtl/start_sequencer.sv
// Light Cycles countdown/phase controller: turns a start edge into 3-2-1-GO,
// gates play via game_en and generates the display multiplex clock segclk.
module start_sequencer
  import light_cycles_pkg::*;
#(
  parameter int TICKS_PER_STEP  = 100_000_000,
  parameter int SEG_HALF_PERIOD = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       crash,
  output logic [2:0] start_counter,
  output logic       game_en,
  output logic       go_pulse,
  output logic       segclk
);

  state_t     state, state_next;
  logic [2:0] start_counter_next;
  logic       game_en_next;
  logic       go_pulse_next;

  logic start_q;
  logic start_armed;
  logic start_rise;
  logic step_en;
  logic step_tc;
  logic seg_tc;

  // start_armed blocks the first cycle after reset so a button already held
  // through release is only loaded into start_q, never seen as an edge.
  assign start_rise = start & ~start_q & start_armed;

  assign step_en = (state == ST_COUNT) || (state == ST_GO);

  tick_divider #(.MODULUS(TICKS_PER_STEP)) u_step_timer (
    .clk (clk),
    .rst (rst),
    .en  (step_en),
    .clr (~step_en),
    .tc  (step_tc)
  );

  tick_divider #(.MODULUS(SEG_HALF_PERIOD)) u_seg_divider (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .clr (1'b0),
    .tc  (seg_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      start_counter <= SC_BLANK;
      game_en       <= 1'b0;
      go_pulse      <= 1'b0;
      segclk        <= 1'b0;
      start_q       <= 1'b0;
      start_armed   <= 1'b0;
    end else begin
      state         <= state_next;
      start_counter <= start_counter_next;
      game_en       <= game_en_next;
      go_pulse      <= go_pulse_next;
      start_q       <= start;
      start_armed   <= 1'b1;
      if (seg_tc) segclk <= ~segclk;
    end
  end

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_next         = state;
    start_counter_next = start_counter;

    case (state)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          state_next         = ST_COUNT;
          start_counter_next = SC_THREE;
        end
      end
      ST_COUNT: begin
        if (step_tc) begin
          if (start_counter == SC_ONE) begin
            state_next         = ST_GO;
            start_counter_next = SC_GO;
          end else begin
            start_counter_next = start_counter + 3'd1;
          end
        end
      end
      ST_GO: begin
        // A crash on the final GO tick takes priority over moving to RUN.
        if (crash) begin
          state_next         = ST_OVER;
          start_counter_next = SC_BLANK;
        end else if (step_tc) begin
          state_next         = ST_RUN;
          start_counter_next = SC_BLANK;
        end
      end
      ST_RUN: begin
        if (crash) begin
          state_next         = ST_OVER;
          start_counter_next = SC_BLANK;
        end
      end
      default: begin
        state_next         = ST_IDLE;
        start_counter_next = SC_BLANK;
      end
    endcase

    game_en_next  = (state_next == ST_GO) || (state_next == ST_RUN);
    go_pulse_next = (state_next == ST_GO) && (state != ST_GO);
  end

endmodule
